// File: rtl/cache_pkg.sv
// cache_pkg
//    Shared definitions for the cache line refill path.
//    state_t  : refill controller state encoding
//    tag_w()  : tag field width from address/line/cache widths
//    idx_w()  : word-index width from the line width
//    BEAT_W / LAST_BEAT : burst beat counter width and final beat value
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB_ADDR = 3'd1,
      WB_DATA = 3'd2,
      RF_ADDR = 3'd3,
      RF_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   // A line burst is always 16 beats; the counter wraps back to 0 after the last one.
   localparam int              BEAT_W    = 4;
   localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

   function automatic int tag_w(input int addr_width, input int line_width, input int cache_width);
      return addr_width - line_width - cache_width;
   endfunction

   // Word index inside a line: bytes-per-line log2 minus the 4-byte word offset.
   function automatic int idx_w(input int line_width);
      return line_width - 2;
   endfunction

endpackage

// File: rtl/line_refill.sv
// line_refill
//    Miss handler for one cache line. On an accepted miss it optionally writes
//    back the dirty victim line as a 16-beat burst, then refills the line with
//    a 16-beat read burst and pulses done.
// Ports
//    clk, rst                      : clock, asynchronous active-low reset
//    req_valid/req_ready           : miss request handshake
//    req_addr/req_dirty/req_victim_tag : miss address, victim dirty flag, victim tag
//    done                          : one-cycle completion pulse
//    line_*                        : write port into the cache line storage
//    line_rdata                    : cache line read data (combinational on line_index)
//    mem_req_*                     : burst address channel to memory
//    mem_w*                        : writeback beat channel
//    mem_rvalid/mem_rdata          : refill beat channel (always accepted)
module line_refill
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int LINE_WIDTH  = 6,
   parameter int CACHE_WIDTH = 6,
   localparam int TAG_W = tag_w(ADDR_WIDTH, LINE_WIDTH, CACHE_WIDTH),
   localparam int IDX_W = idx_w(LINE_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_dirty,
   input  logic [TAG_W-1:0]      req_victim_tag,
   output logic                  done,
   output logic                  line_write_en,
   output logic                  line_valid,
   output logic                  line_dirty,
   output logic [TAG_W-1:0]      line_tag,
   output logic [IDX_W-1:0]      line_index,
   output logic [3:0]            line_byte_en,
   output logic [DATA_WIDTH-1:0] line_wdata,
   input  logic [DATA_WIDTH-1:0] line_rdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_write,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic                  mem_wvalid,
   input  logic                  mem_wready,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wlast,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int LADDR_W = ADDR_WIDTH - LINE_WIDTH;

   state_t              state_reg, state_next;
   logic [BEAT_W-1:0]   beat_reg, beat_next;
   logic [LADDR_W-1:0]  line_addr_reg;   // miss address without the byte-in-line offset
   logic [TAG_W-1:0]    victim_reg;
   logic                accept;

   // Byte offset within the line never matters for a whole-line transfer.
   logic unused_offset;
   assign unused_offset = ^req_addr[LINE_WIDTH-1:0];

   assign accept = req_valid && (state_reg == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         beat_reg      <= '0;
         line_addr_reg <= '0;
         victim_reg    <= '0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         if (accept) begin
            line_addr_reg <= req_addr[ADDR_WIDTH-1:LINE_WIDTH];
            victim_reg    <= req_victim_tag;
         end
      end
   end

   // Data paths are unconditional; the strobes below qualify them.
   assign line_index   = IDX_W'(beat_reg);
   assign mem_wdata    = line_rdata;
   assign line_wdata   = mem_rdata;
   assign line_tag     = line_addr_reg[LADDR_W-1 -: TAG_W];
   assign line_dirty   = 1'b0;
   assign line_byte_en = 4'hF;

   always_comb begin
      state_next    = state_reg;
      beat_next     = beat_reg;
      req_ready     = 1'b0;
      done          = 1'b0;
      line_write_en = 1'b0;
      line_valid    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_req_addr  = '0;
      mem_wvalid    = 1'b0;
      mem_wlast     = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = req_dirty ? WB_ADDR : RF_ADDR;
            end
         end
         WB_ADDR: begin
            // Victim lives at the same set index, under its own tag.
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_addr  = {victim_reg, line_addr_reg[CACHE_WIDTH-1:0], {LINE_WIDTH{1'b0}}};
            if (mem_req_ready) begin
               state_next = WB_DATA;
               beat_next  = '0;
            end
         end
         WB_DATA: begin
            mem_wvalid = 1'b1;
            mem_wlast  = (beat_reg == LAST_BEAT);
            if (mem_wready) begin
               beat_next = beat_reg + 1'b1;
               if (beat_reg == LAST_BEAT) begin
                  state_next = RF_ADDR;
               end
            end
         end
         RF_ADDR: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {line_addr_reg, {LINE_WIDTH{1'b0}}};
            if (mem_req_ready) begin
               state_next = RF_DATA;
               beat_next  = '0;
            end
         end
         RF_DATA: begin
            if (mem_rvalid) begin
               line_write_en = 1'b1;
               // The line becomes valid only with its final word.
               line_valid    = (beat_reg == LAST_BEAT);
               beat_next     = beat_reg + 1'b1;
               if (beat_reg == LAST_BEAT) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_line_refill.sv
module tb_line_refill;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid, req_ready, req_dirty, done;
   logic [31:0] req_addr;
   logic [19:0] req_victim_tag;
   logic        line_write_en, line_valid, line_dirty;
   logic [19:0] line_tag;
   logic [3:0]  line_index, line_byte_en;
   logic [31:0] line_wdata, line_rdata;
   logic        mem_req_valid, mem_req_ready, mem_req_write;
   logic [31:0] mem_req_addr;
   logic        mem_wvalid, mem_wready, mem_wlast;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   line_refill dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_dirty(req_dirty), .req_victim_tag(req_victim_tag), .done(done),
      .line_write_en(line_write_en), .line_valid(line_valid), .line_dirty(line_dirty),
      .line_tag(line_tag), .line_index(line_index), .line_byte_en(line_byte_en),
      .line_wdata(line_wdata), .line_rdata(line_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_wlast(mem_wlast), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   // Cache line storage model and the memory's contents for the line being refilled.
   logic [31:0] line_mem [16];
   logic [31:0] rf_data  [16];
   assign line_rdata = line_mem[line_index];

   typedef struct { bit wr; logic [31:0] addr; } req_t;
   typedef struct { logic [31:0] d; bit last; } wb_t;
   typedef struct { logic [3:0] idx; logic [31:0] d; logic [19:0] tag; bit v; } lw_t;

   req_t exp_req[$];
   wb_t  exp_w[$];
   lw_t  exp_lw[$];
   int   exp_done = 0;

   int checks = 0;
   int failures = 0;
   int lw_count = 0;
   bit wtoggle_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   // Monitor: pops expectations whenever the DUT presents a transfer.
   initial begin : monitor
      req_t r;
      wb_t  w;
      lw_t  l;
      bit   wstall, rqstall, last_seen;
      logic [31:0] wstall_d, rqstall_a;
      wstall = 0; rqstall = 0; last_seen = 0;
      wstall_d = '0; rqstall_a = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            wstall = 0; rqstall = 0; last_seen = 0;
         end else begin
            if (rqstall) chk("req_payload_stable", {31'd0, mem_req_valid, mem_req_addr}, {31'd0, 1'b1, rqstall_a});
            if (wstall)  chk("wdata_stable", {31'd0, mem_wvalid, mem_wdata}, {31'd0, 1'b1, wstall_d});
            if (last_seen) chk("done_after_last_beat", done, 1);
            rqstall = mem_req_valid && !mem_req_ready; rqstall_a = mem_req_addr;
            wstall  = mem_wvalid && !mem_wready;       wstall_d  = mem_wdata;
            last_seen = 0;
            if (mem_req_valid && mem_req_ready) begin
               if (exp_req.size() == 0) unexpected("mem_req");
               else begin
                  r = exp_req.pop_front();
                  chk("mem_req_addr", mem_req_addr, r.addr);
                  chk("mem_req_write", mem_req_write, r.wr);
               end
            end
            if (mem_wvalid && mem_wready) begin
               if (exp_w.size() == 0) unexpected("wbeat");
               else begin
                  w = exp_w.pop_front();
                  chk("wdata", mem_wdata, w.d);
                  chk("wlast", mem_wlast, w.last);
               end
            end
            if (line_write_en) begin
               lw_count++;
               if (exp_lw.size() == 0) unexpected("line_write_en");
               else begin
                  l = exp_lw.pop_front();
                  chk("line_index", line_index, l.idx);
                  chk("line_wdata", line_wdata, l.d);
                  chk("line_tag", line_tag, l.tag);
                  chk("line_valid", line_valid, l.v);
                  chk("line_byte_en", line_byte_en, 4'hF);
                  chk("line_dirty", line_dirty, 0);
                  last_seen = l.v;
               end
            end
            if (done) begin
               if (exp_done == 0) unexpected("done");
               else exp_done--;
            end
         end
      end
   end

   // Memory responder: random ready, in-order refill beats, rvalid noise otherwise.
   initial begin : slave
      bit in_refill, req_hs, r_hs;
      int rbeat;
      in_refill = 0; rbeat = 0;
      mem_req_ready = 0; mem_wready = 0; mem_rvalid = 0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         req_hs = mem_req_valid && mem_req_ready && !mem_req_write;
         r_hs   = mem_rvalid && in_refill;
         @(posedge clk);
         #1;
         if (!rst) begin
            in_refill = 0;
         end else begin
            if (r_hs) begin
               rbeat++;
               if (rbeat == 16) in_refill = 0;
            end
            if (req_hs) begin
               in_refill = 1;
               rbeat = 0;
            end
         end
         mem_req_ready = ($urandom_range(0, 2) != 0);
         mem_wready    = wtoggle_mode ? ~mem_wready : ($urandom_range(0, 3) != 0);
         if (in_refill) begin
            mem_rvalid = ($urandom_range(0, 2) != 0);
            mem_rdata  = mem_rvalid ? rf_data[rbeat] : $urandom;
         end else begin
            mem_rvalid = ($urandom_range(0, 1) != 0);
            mem_rdata  = $urandom;
         end
      end
   end

   // Reference model: a miss produces an optional 16-word writeback of the
   // victim, then a 16-word refill of the missing line, then one done.
   task automatic expect_txn(input logic [31:0] addr, input bit dirty, input logic [19:0] vtag);
      req_t r;
      wb_t  w;
      lw_t  l;
      for (int i = 0; i < 16; i++) begin
         line_mem[i] = $urandom;
         rf_data[i]  = $urandom;
      end
      if (dirty) begin
         r.wr = 1; r.addr = (32'(vtag) << 12) | (addr & 32'h0000_0FC0);
         exp_req.push_back(r);
         for (int i = 0; i < 16; i++) begin
            w.d = line_mem[i]; w.last = (i == 15);
            exp_w.push_back(w);
         end
      end
      r.wr = 0; r.addr = addr & 32'hFFFF_FFC0;
      exp_req.push_back(r);
      for (int i = 0; i < 16; i++) begin
         l.idx = 4'(i); l.d = rf_data[i]; l.tag = addr[31:12]; l.v = (i == 15);
         exp_lw.push_back(l);
      end
      exp_done++;
   endtask

   task automatic issue(input logic [31:0] addr, input bit dirty, input logic [19:0] vtag, input bit hold);
      int n;
      @(posedge clk);
      #1;
      req_valid = 1; req_addr = addr; req_dirty = dirty; req_victim_tag = vtag;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 50);
      chk("accept_timeout", req_ready, 1);
      @(posedge clk);
      #1;
      if (!hold) begin
         req_valid = 0; req_addr = $urandom; req_dirty = 1'($urandom); req_victim_tag = 20'($urandom);
      end
   endtask

   task automatic run_txn(input logic [31:0] addr, input bit dirty, input logic [19:0] vtag, input bit hold);
      int n;
      bit got, busy_ready;
      expect_txn(addr, dirty, vtag);
      issue(addr, dirty, vtag, hold);
      n = 0; got = 0; busy_ready = 0;
      while (n < 3000 && !got) begin
         @(negedge clk);
         n++;
         if (done) got = 1;
         else if (req_ready) busy_ready = 1;
      end
      chk("done_seen", got, 1);
      chk("ready_low_while_busy", busy_ready, 0);
      @(posedge clk);
      #1;
      req_valid = 0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("ready_after_done", req_ready, 1);
      $display("txn addr=%08h dirty=%0d vtag=%05h hold=%0d cycles=%0d", addr, dirty, vtag, hold, n);
   endtask

   task automatic reset_mid_refill(input logic [31:0] addr);
      int n, base;
      base = lw_count;
      expect_txn(addr, 0, 20'h0);
      issue(addr, 0, 20'h0, 0);
      n = 0;
      while (lw_count < base + 7 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_beat7", (lw_count >= base + 7), 1);
      #2;
      rst = 0;
      #1;
      exp_req.delete(); exp_w.delete(); exp_lw.delete(); exp_done = 0;
      chk("rst_line_write_en", line_write_en, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_wvalid", mem_wvalid, 0);
      chk("rst_done", done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1;
      @(negedge clk);
      chk("ready_after_reset", req_ready, 1);
      repeat (5) @(negedge clk);
      $display("txn reset at refill beat %0d addr=%08h", lw_count - base, addr);
   endtask

   initial begin : stim
      logic [31:0] a;
      req_valid = 0; req_addr = '0; req_dirty = 0; req_victim_tag = '0;
      for (int i = 0; i < 16; i++) begin
         line_mem[i] = '0;
         rf_data[i]  = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_mem_req_valid", mem_req_valid, 0);
      chk("reset_mem_wvalid", mem_wvalid, 0);
      chk("reset_done", done, 0);
      chk("reset_line_write_en", line_write_en, 0);
      #2;
      rst = 1;
      @(negedge clk);
      chk("reset_req_ready", req_ready, 1);
      repeat (4) @(negedge clk);   // rvalid noise while idle

      run_txn(32'h0000_1040, 0, 20'h0, 0);
      run_txn(32'h0000_1040, 1, 20'hABCDE, 0);
      wtoggle_mode = 1;
      run_txn($urandom, 1, 20'($urandom), 0);
      wtoggle_mode = 0;
      run_txn($urandom, 0, 20'($urandom), 1);
      run_txn($urandom, 1, 20'($urandom), 1);
      reset_mid_refill(32'h0000_2080);
      run_txn(32'h0000_2080, 0, 20'h0, 0);
      for (int k = 0; k < 6; k++) begin
         a = $urandom;
         run_txn(a, 1'($urandom), 20'($urandom), 1'($urandom));
      end

      repeat (5) @(negedge clk);
      chk("leftover_req", exp_req.size(), 0);
      chk("leftover_wbeat", exp_w.size(), 0);
      chk("leftover_line_write", exp_lw.size(), 0);
      chk("leftover_done", exp_done, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
